// File: rtl/bram_fifo_pkg.sv
// rtl/bram_fifo_pkg.sv - shared constants and width helpers for bram_fifo
package bram_fifo_pkg;

  // Output buffer holds a head entry plus one skid entry.
  localparam int unsigned BUF_ENTRIES = 2;

  // Width of the total-occupancy counter: memory words + one in flight + buffer.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + BUF_ENTRIES + 1);
  endfunction

endpackage

// File: rtl/dual_port_memory.sv
// rtl/dual_port_memory.sv - simple dual-port block RAM, one write port, one registered read port
//
// Ports:
//   write_clock, write_clock_enable, write_enable, write_address, write_data : write port
//   read_clock, read_clock_enable, read_enable, read_address                 : read port
//   read_data : word at read_address, valid one cycle after a read enable
module dual_port_memory #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 256
) (
  input  logic                     write_clock,
  input  logic                     write_clock_enable,
  input  logic                     write_enable,
  input  logic [$clog2(DEPTH)-1:0] write_address,
  input  logic [WIDTH-1:0]         write_data,
  input  logic                     read_clock,
  input  logic                     read_clock_enable,
  input  logic                     read_enable,
  input  logic [$clog2(DEPTH)-1:0] read_address,
  output logic [WIDTH-1:0]         read_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // No reset: block RAM contents and output register are not resettable.
  always_ff @(posedge write_clock) begin
    if (write_clock_enable && write_enable) begin
      mem_q[write_address] <= write_data;
    end
  end

  always_ff @(posedge read_clock) begin
    if (read_clock_enable && read_enable) begin
      read_data <= mem_q[read_address];
    end
  end

endmodule

// File: rtl/bram_fifo.sv
// rtl/bram_fifo.sv - first-word-fall-through stream FIFO built on a dual-port block RAM
//
// Ports:
//   clock, reset_n                 : sole clock, asynchronous active-low reset
//   in_data, in_valid, in_ready    : producer side handshake
//   out_data, out_valid, out_ready : consumer side handshake, out_data registered
//   count                          : words held (memory + in flight + output buffer)
module bram_fifo
  import bram_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 256
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+3)-1:0] count
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned MCW = $clog2(DEPTH + 1);
  localparam int unsigned CW  = count_width(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [MCW-1:0]   mem_count_q, mem_count_d;
  logic             in_flight_q, in_flight_d;
  logic [1:0]       buffered_q, buffered_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  logic             push;
  logic             pop;
  logic             read_issue;
  logic [2:0]       occupancy;
  logic [WIDTH-1:0] read_data;

  assign in_ready  = (mem_count_q != MCW'(DEPTH));
  assign out_valid = (buffered_q != 2'd0);
  assign out_data  = head_q;
  assign count     = CW'(mem_count_q) + CW'(in_flight_q) + CW'(buffered_q);

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Words already committed to the output side (buffered or returning from RAM).
  // A read is only issued if its word is guaranteed a free buffer entry once
  // this cycle's pop is accounted for.
  assign occupancy  = {1'b0, buffered_q} + {2'b00, in_flight_q};
  assign read_issue = (mem_count_q != '0) && (occupancy < (3'd2 + {2'b00, pop}));

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_count_d = mem_count_q;
    in_flight_d = read_issue;
    head_d      = head_q;
    skid_d      = skid_q;
    buffered_d  = buffered_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (read_issue) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push, read_issue})
      2'b10:   mem_count_d = mem_count_q + MCW'(1);
      2'b01:   mem_count_d = mem_count_q - MCW'(1);
      default: mem_count_d = mem_count_q;
    endcase

    // Pop first, then the returning word lands in the first free entry.
    if (pop) begin
      head_d     = skid_q;
      buffered_d = buffered_q - 2'd1;
    end
    if (in_flight_q) begin
      if (buffered_d == 2'd0) begin
        head_d = read_data;
      end else begin
        skid_d = read_data;
      end
      buffered_d = buffered_d + 2'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
      in_flight_q <= 1'b0;
      buffered_q  <= 2'd0;
      head_q      <= '0;
      skid_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      in_flight_q <= in_flight_d;
      buffered_q  <= buffered_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
    end
  end

  // Read and write addresses never collide: reads only target committed
  // words, and a push is impossible while the memory is full.
  dual_port_memory #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .write_clock        (clock),
    .write_clock_enable (1'b1),
    .write_enable       (push),
    .write_address      (wr_ptr_q),
    .write_data         (in_data),
    .read_clock         (clock),
    .read_clock_enable  (1'b1),
    .read_enable        (read_issue),
    .read_address       (rd_ptr_q),
    .read_data          (read_data)
  );

endmodule

// File: tb/tb_bram_fifo.sv
// tb/tb_bram_fifo.sv - randomized scoreboard bench for bram_fifo
module tb_bram_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 256;
  localparam int CW    = $clog2(DEPTH + 3);

  logic             clock = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;

  bram_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               edge_no;
  } entry_t;

  entry_t model_q[$];
  int     edge_no = 0;
  int     errors  = 0;
  int     checks  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Oldest word is visible once two edges have passed since it was pushed.
  function automatic bit exp_valid();
    if (model_q.size() == 0) return 1'b0;
    return (edge_no - model_q[0].edge_no) >= 2;
  endfunction

  task automatic check_state();
    check("count", 32'(count), 32'(model_q.size()));
    check("out_valid", 32'(out_valid), 32'(exp_valid()));
    if (exp_valid()) check("out_data", 32'(out_data), 32'(model_q[0].data));
    if (model_q.size() < DEPTH) check("in_ready", 32'(in_ready), 32'd1);
    else if (model_q.size() == DEPTH + 2) check("in_ready_full", 32'(in_ready), 32'd0);
  endtask

  // One clock cycle: drive at the falling edge, commit at the rising edge,
  // compare at the next falling edge.
  task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit r);
    bit     do_push;
    bit     do_pop;
    entry_t e;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    do_push   = v && in_ready;
    do_pop    = r && exp_valid();
    @(posedge clock);
    edge_no++;
    if (do_pop) void'(model_q.pop_front());
    if (do_push) begin
      e.data    = d;
      e.edge_no = edge_no;
      model_q.push_back(e);
    end
    @(negedge clock);
    check_state();
  endtask

  task automatic drain();
    int n = 0;
    while (model_q.size() > 0 && n < 2000) begin
      step(1'b0, '0, 1'b1);
      n++;
    end
    check("drained", 32'(count), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", 32'(out_data), 32'd0);
    reset_n = 1'b1;

    // Fall-through latency on an empty FIFO.
    step(1'b1, 16'h1234, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    check("ft_valid", 32'(out_valid), 32'd1);
    check("ft_data", 32'(out_data), 32'h1234);
    check("ft_count", 32'(count), 32'd1);
    drain();

    // Full-rate streaming.
    for (int i = 0; i < 300; i++) begin
      step(1'b1, WIDTH'(i), 1'b1);
      check("stream_in_ready", 32'(in_ready), 32'd1);
    end
    drain();

    // Fill to capacity with the consumer stalled.
    begin
      int n = 0;
      while (in_ready && n < 400) begin
        step(1'b1, WIDTH'($urandom), 1'b0);
        n++;
      end
    end
    check("full_count", 32'(count), 32'(DEPTH + 2));
    check("full_ready", 32'(in_ready), 32'd0);
    step(1'b1, 16'hdead, 1'b0);
    check("full_ignored", 32'(count), 32'(DEPTH + 2));
    drain();

    // Pointer wrap.
    repeat (200) step(1'b1, WIDTH'($urandom), 1'b0);
    drain();
    repeat (300) step(1'b1, WIDTH'($urandom), 1'b1);
    drain();

    // Random handshakes.
    repeat (10000) step(1'($urandom % 2), WIDTH'($urandom), 1'($urandom % 2));
    drain();

    // Reset mid-stream with words in memory and one read in flight.
    repeat (8) step(1'b1, WIDTH'($urandom), 1'b0);
    step(1'b0, '0, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("mid_rst_hold_valid", 32'(out_valid), 32'd0);
    model_q.delete();
    reset_n = 1'b1;
    repeat (4) step(1'b0, '0, 1'b1);
    step(1'b1, 16'h0abc, 1'b0);
    step(1'b1, 16'h0def, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    check("post_rst_head", 32'(out_data), 32'h0abc);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
